multi_channel_watchdog: RTL and testbench
=========================================

# multi_channel_watchdog

Synthesizable N-channel watchdog for the core run-control path. It replaces the single free-running up-counter watchdog with per-channel programmable down-counters. Each channel has kick/reload, an optional pre-timeout warning stage, sticky expiry and first-expiry capture. It sits beside CoreTop and is driven by the core (or bench) to detect hung fetch/decode/memory activity and stalled tests.

## Interface
- NUM_CH, 4, number of independent watchdog channels (1..16)
- CNT_W, 16, width of each channel's timeout counter
- PRESCALE, 1, clk cycles per count tick (>=1); shared by all channels
- WARN_MARGIN, 8, count value at or below which a running channel enters WARN (must be < 2^CNT_W)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  NUM_CH  per-channel enable; level-sensitive
- kick  in  NUM_CH  per-channel reload pulse
- clear  in  NUM_CH  per-channel expiry clear pulse
- cfg_we  in  1  timeout register write strobe
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel selected for write
- cfg_timeout  in  CNT_W  timeout value written
- warn  out  NUM_CH  channel in WARN state (registered)
- expired  out  NUM_CH  sticky expiry flag (registered)
- any_expired  out  1  OR of expired
- first_ch  out  $clog2(NUM_CH) (min 1)  index of the first channel that expired; valid while any_expired
- count_val  out  NUM_CH*CNT_W  live counters, channel i at [i*CNT_W +: CNT_W]

## Operation
- Per-channel FSM states: IDLE, RUN, WARN, EXPIRED.
- IDLE -> RUN when en=1. Count is loaded with the channel's timeout register at the same edge.
- RUN/WARN: on each tick with count>0, decrement. On a tick with count==0, go to EXPIRED.
- RUN -> WARN when count <= WARN_MARGIN. WARN -> RUN only via kick.
- kick in RUN/WARN reloads count from the timeout register and goes to RUN. kick has priority over a same-cycle tick or expiry.
- en=0 in RUN/WARN -> IDLE with count cleared. en is ignored in EXPIRED.
- EXPIRED is sticky. kick and en are ignored. clear -> IDLE, count 0. clear in any other state has no effect.
- Timeout register write (cfg_we) does not disturb a running count; the new value is used at the next load or kick. cfg_ch >= NUM_CH writes are dropped.
- Timeout 0: the channel expires on the first tick after entering RUN.
- first_ch is latched on the cycle any_expired goes 0->1. On simultaneous expiries, the lowest index wins. It is held until all channels are cleared, then returns to 0.
- Prescaler: a shared counter 0..PRESCALE-1. tick = (prescaler == PRESCALE-1). PRESCALE=1 gives tick every cycle.

## Timing
- Reset values: all states IDLE, counts 0, timeout registers all-ones, prescaler 0, warn=0, expired=0, any_expired=0, first_ch=0.
- Reset mid-operation overrides everything, including EXPIRED and pending kick/clear.
- With en sampled high at edge k (PRESCALE=1, timeout T): count=T at k, count 0 at k+T, expired=1 at edge k+T+1.
- With PRESCALE=P: expiry occurs on the (T+1)th tick after entering RUN. Latency is also offset by the prescaler phase, which is not reset on kick.
- warn, expired and first_ch are registered outputs. any_expired is combinational OR of registered expired.
- clear at edge m: expired=0 after edge m. A re-arm needs en high, giving RUN at edge m+1 at the earliest.

## Configuration
- WATCHDOG_WARN_EN defined: the WARN state and warn outputs are implemented as above.
- WATCHDOG_WARN_EN undefined: WARN is never entered, warn is tied 0, and the WARN_MARGIN compare logic is removed. Expiry timing is unchanged.

## Structure
- Package watchdog_pkg holds:
  - the wdog_state_e enum (IDLE, RUN, WARN, EXPIRED);
  - default CNT_W and PRESCALE constants;
  - the reset timeout constant.
- Sub-module watchdog_channel: one FSM, counter and timeout register per channel. It is instantiated NUM_CH times in a generate loop.
- The top level holds the shared prescaler, config decode, the any_expired OR, and the first_ch capture.

## Test plan
- Basic expiry: PRESCALE=1, write ch0 timeout=10, en[0] high before edge 0 -> count_val ch0 = 10 at edge 0, expired[0]=1 at edge 11, first_ch=0, any_expired=1.
- Kick: timeout=10, kick[0] at edge 5 -> count reloads to 10 at edge 5. No expiry before edge 16, expired at edge 16. A kick coincident with count==0 reloads and does not expire.
- Warn (macro on): timeout=20, WARN_MARGIN=8 -> warn[0] rises when count reaches 8 and clears on kick. With macro off, warn stays 0 and expiry timing is identical.
- Simultaneous expiry: ch1 and ch3 with timeout=5 and the same enable edge -> both expired, first_ch=1. Clearing ch1 only keeps first_ch=1. Clearing both drops any_expired and resets first_ch to 0.
- Prescaler: PRESCALE=4, timeout=3 -> expiry after 4 ticks (<=16 cycles, >=13 cycles from enable). A mid-run write of timeout=100 does not affect the current run.
- Reset mid-run and in EXPIRED: assert rst for one cycle -> all outputs return to reset values next edge. With en still high, the channel re-enters RUN with timeout all-ones.

Source files
------------

// File: rtl/watchdog_pkg.sv
// watchdog_pkg: shared types and constants for the multi-channel watchdog.
//   wdog_state_e  per-channel FSM state (IDLE, RUN, WARN, EXPIRED)
//   DEF_CNT_W     default counter width
//   DEF_PRESCALE  default clk cycles per count tick
//   RST_TIMEOUT   timeout register reset value (all-ones, truncated to CNT_W)
package watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WARN    = 2'd2,
    EXPIRED = 2'd3
  } wdog_state_e;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_PRESCALE = 1;

  // Cast down to CNT_W at the use site; all-ones stays all-ones for CNT_W <= 32.
  localparam logic [31:0] RST_TIMEOUT = 32'hFFFF_FFFF;

endpackage

// File: rtl/multi_channel_watchdog_if.sv
// multi_channel_watchdog_if: control and status bundle of the watchdog.
//   master: drives en/kick/clear and the timeout write port, observes status
//   slave : the watchdog itself
//   en/kick/clear   per-channel enable level, reload pulse, expiry clear pulse
//   cfg_we/cfg_ch/cfg_timeout  timeout register write port
//   warn/expired    per-channel registered status
//   any_expired     OR of expired
//   first_ch        index of the first channel to expire
//   count_val       live counters, channel i at [i*CNT_W +: CNT_W]
interface multi_channel_watchdog_if
  import watchdog_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       kick;
  logic [NUM_CH-1:0]       clear;
  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [CNT_W-1:0]        cfg_timeout;
  logic [NUM_CH-1:0]       warn;
  logic [NUM_CH-1:0]       expired;
  logic                    any_expired;
  logic [CH_W-1:0]         first_ch;
  logic [NUM_CH*CNT_W-1:0] count_val;

  modport master (
    output en, kick, clear, cfg_we, cfg_ch, cfg_timeout,
    input  warn, expired, any_expired, first_ch, count_val
  );

  modport slave (
    input  en, kick, clear, cfg_we, cfg_ch, cfg_timeout,
    output warn, expired, any_expired, first_ch, count_val
  );

endinterface

// File: rtl/watchdog_channel.sv
// watchdog_channel: one watchdog channel (FSM, down-counter, timeout register).
// Build option: WATCHDOG_WARN_EN enables the WARN state and the warn output;
// without it WARN is never entered and warn is tied low.
//   clk, rst     clock, synchronous active-high reset
//   tick         shared prescaler tick
//   en/kick/clear  enable level, reload pulse, expiry clear pulse
//   cfg_we, cfg_timeout  timeout register write (already decoded for this channel)
//   count        live counter value
//   warn, expired  state flags
//   expired_nxt  expired value after the coming edge (for first-expiry capture)
module watchdog_channel
  import watchdog_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WARN_MARGIN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             kick,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_timeout,
  output logic [CNT_W-1:0] count,
  output logic             warn,
  output logic             expired,
  output logic             expired_nxt
);

  if (longint'(WARN_MARGIN) < 0 || longint'(WARN_MARGIN) >= (longint'(1) << CNT_W)) begin : g_margin_chk
    $error("WARN_MARGIN must lie in 0 .. 2^CNT_W-1");
  end

`ifdef WATCHDOG_WARN_EN
  localparam logic [CNT_W-1:0] WARN_LVL = CNT_W'(WARN_MARGIN);
`endif

  wdog_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] timeout_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = count;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          cnt_nxt   = timeout_q;
        end
      end
      RUN, WARN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (kick) begin
          // Kick beats a same-cycle tick, including the expiring one.
          state_nxt = RUN;
          cnt_nxt   = timeout_q;
        end else if (tick && (count == '0)) begin
          state_nxt = EXPIRED;
        end else begin
          if (tick) cnt_nxt = count - CNT_W'(1);
`ifdef WATCHDOG_WARN_EN
          // Judged on the post-edge count so warn rises with the count reaching the margin.
          if (cnt_nxt <= WARN_LVL) state_nxt = WARN;
`endif
        end
      end
      EXPIRED: begin
        if (clear) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      timeout_q <= CNT_W'(RST_TIMEOUT);
    end else begin
      state <= state_nxt;
      count <= cnt_nxt;
      // A write only affects later loads; the running count is left alone.
      if (cfg_we) timeout_q <= cfg_timeout;
    end
  end

  assign expired     = (state == EXPIRED);
  assign expired_nxt = (state_nxt == EXPIRED);

`ifdef WATCHDOG_WARN_EN
  assign warn = (state == WARN);
`else
  assign warn = 1'b0;
`endif

endmodule

// File: rtl/multi_channel_watchdog.sv
// multi_channel_watchdog: NUM_CH independent programmable down-counter watchdogs
// with a shared prescaler, sticky expiry and first-expiry capture.
// Build option: WATCHDOG_WARN_EN enables the pre-timeout WARN stage.
//   clk  single clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  multi_channel_watchdog_if.slave: en/kick/clear, timeout write port,
//        warn/expired/any_expired/first_ch/count_val status
module multi_channel_watchdog
  import watchdog_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int WARN_MARGIN = 8
) (
  input logic                     clk,
  input logic                     rst,
  multi_channel_watchdog_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]         presc;
  logic                    tick;
  logic [NUM_CH-1:0]       ch_we;
  logic [NUM_CH-1:0]       warn_v;
  logic [NUM_CH-1:0]       exp_v;
  logic [NUM_CH-1:0]       exp_nxt_v;
  logic [NUM_CH*CNT_W-1:0] cnt_v;
  logic [CH_W-1:0]         first_q;

  function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CH_W'(i);
    end
  endfunction

  // Free-running prescaler; kicks do not realign its phase.
  assign tick = (presc == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PS_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range cfg_ch values match no channel and are dropped.
    assign ch_we[i] = bus.cfg_we && (int'(bus.cfg_ch) == i);

    watchdog_channel #(
      .CNT_W       (CNT_W),
      .WARN_MARGIN (WARN_MARGIN)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .en          (bus.en[i]),
      .kick        (bus.kick[i]),
      .clear       (bus.clear[i]),
      .cfg_we      (ch_we[i]),
      .cfg_timeout (bus.cfg_timeout),
      .count       (cnt_v[i*CNT_W +: CNT_W]),
      .warn        (warn_v[i]),
      .expired     (exp_v[i]),
      .expired_nxt (exp_nxt_v[i])
    );
  end

  // Capture on the edge that takes any_expired from 0 to 1, hold while any
  // channel stays expired, and drop to 0 once every channel is cleared.
  always_ff @(posedge clk) begin
    if (rst)               first_q <= '0;
    else if (~|exp_nxt_v)  first_q <= '0;
    else if (~|exp_v)      first_q <= lowest_idx(exp_nxt_v);
  end

  assign bus.warn        = warn_v;
  assign bus.expired     = exp_v;
  assign bus.any_expired = |exp_v;
  assign bus.first_ch    = first_q;
  assign bus.count_val   = cnt_v;

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// tb_multi_channel_watchdog: table-driven, hand-written and randomized checks of
// multi_channel_watchdog. Two instances share one stimulus: PRESCALE=1 and PRESCALE=4.
module tb_multi_channel_watchdog;
  import watchdog_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 16;
  localparam int CH_W        = 2;
  localparam int WARN_MARGIN = 8;

`ifdef WATCHDOG_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_channel_watchdog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  multi_channel_watchdog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus4 ();

  assign bus4.en          = bus.en;
  assign bus4.kick        = bus.kick;
  assign bus4.clear       = bus.clear;
  assign bus4.cfg_we      = bus.cfg_we;
  assign bus4.cfg_ch      = bus.cfg_ch;
  assign bus4.cfg_timeout = bus.cfg_timeout;

  multi_channel_watchdog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(1), .WARN_MARGIN(WARN_MARGIN))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  multi_channel_watchdog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(4), .WARN_MARGIN(WARN_MARGIN))
    dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Per channel: armed (counting), warned, expired flag, remaining count.
  int m_ps    [2];
  int m_to    [2][NUM_CH];
  int m_cnt   [2][NUM_CH];
  bit m_armed [2][NUM_CH];
  bit m_warned[2][NUM_CH];
  bit m_exp   [2][NUM_CH];
  int m_first [2];

  function automatic int ps_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic model_step(input int d);
    bit tk;
    bit any_before;
    bit any_after;
    tk = (m_ps[d] == ps_of(d) - 1);
    if (rst) begin
      m_ps[d] = 0;
      m_first[d] = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_to[d][c] = 65535; m_cnt[d][c] = 0;
        m_armed[d][c] = 0; m_warned[d][c] = 0; m_exp[d][c] = 0;
      end
      return;
    end
    m_ps[d] = tk ? 0 : m_ps[d] + 1;
    any_before = 0;
    for (int c = 0; c < NUM_CH; c++) any_before |= m_exp[d][c];
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_exp[d][c]) begin
        if (bus.clear[c]) begin m_exp[d][c] = 0; m_cnt[d][c] = 0; end
      end else if (!m_armed[d][c]) begin
        if (bus.en[c]) begin m_armed[d][c] = 1; m_cnt[d][c] = m_to[d][c]; m_warned[d][c] = 0; end
      end else if (!bus.en[c]) begin
        m_armed[d][c] = 0; m_cnt[d][c] = 0; m_warned[d][c] = 0;
      end else if (bus.kick[c]) begin
        m_cnt[d][c] = m_to[d][c]; m_warned[d][c] = 0;
      end else if (tk && m_cnt[d][c] == 0) begin
        m_exp[d][c] = 1; m_armed[d][c] = 0; m_warned[d][c] = 0;
      end else begin
        if (tk) m_cnt[d][c]--;
        if (m_cnt[d][c] <= WARN_MARGIN) m_warned[d][c] = 1;
      end
    end
    if (bus.cfg_we && int'(bus.cfg_ch) < NUM_CH) m_to[d][int'(bus.cfg_ch)] = int'(bus.cfg_timeout);
    any_after = 0;
    for (int c = 0; c < NUM_CH; c++) any_after |= m_exp[d][c];
    if (!any_after) m_first[d] = 0;
    else if (!any_before) begin
      for (int c = NUM_CH - 1; c >= 0; c--) if (m_exp[d][c]) m_first[d] = c;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic compare_model(input int d);
    logic [NUM_CH*CNT_W-1:0] cv;
    logic [NUM_CH-1:0] wv, ev, wx, ex;
    logic any, anyx;
    logic [CH_W-1:0] fc;
    if (d == 0) begin
      cv = bus.count_val; wv = bus.warn; ev = bus.expired; any = bus.any_expired; fc = bus.first_ch;
    end else begin
      cv = bus4.count_val; wv = bus4.warn; ev = bus4.expired; any = bus4.any_expired; fc = bus4.first_ch;
    end
    anyx = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("rnd p%0d cnt%0d", ps_of(d), c), cv[c*CNT_W +: CNT_W], m_cnt[d][c]);
      wx[c] = m_warned[d][c] & WARN_ON;
      ex[c] = m_exp[d][c];
      anyx |= m_exp[d][c];
    end
    chk($sformatf("rnd p%0d warn", ps_of(d)), wv, wx);
    chk($sformatf("rnd p%0d expired", ps_of(d)), ev, ex);
    chk($sformatf("rnd p%0d any", ps_of(d)), any, anyx);
    chk($sformatf("rnd p%0d first", ps_of(d)), fc, m_first[d]);
  endtask

  // ---------------- directed vector table (PRESCALE=1 instance) ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  en, kick, clear;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] to;
    logic [15:0] cnt0;
    logic [3:0]  warn, expd;
    logic        any;
    logic [1:0]  first;
  } vec_t;

  vec_t tbl[23];

  initial begin
    #1000000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int e;

    //           rst   en    kick  clr   we    ch    to       cnt0      warn  exp   any   first
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0, 16'd3,  16'd0,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd3,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[3]  = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd2,    4'h1, 4'h0, 1'b0, 2'd0};
    tbl[4]  = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 16'd0,  16'd3,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[5]  = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd2,    4'h1, 4'h0, 1'b0, 2'd0};
    tbl[6]  = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd1,    4'h1, 4'h0, 1'b0, 2'd0};
    tbl[7]  = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h1, 4'h0, 1'b0, 2'd0};
    tbl[8]  = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 16'd0,  16'd3,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd2,    4'h1, 4'h0, 1'b0, 2'd0};
    tbl[10] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd1,    4'h1, 4'h0, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h1, 4'h0, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h0, 4'h1, 1'b1, 2'd0};
    tbl[13] = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h0, 4'h1, 1'b1, 2'd0};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 2'd0, 16'd0,  16'd0,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[15] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd3,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[16] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[17] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0, 16'd0,  16'd0,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[18] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[19] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h0, 4'h1, 1'b1, 2'd0};
    tbl[20] = '{1'b1, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'd0,    4'h0, 4'h0, 1'b0, 2'd0};
    tbl[21] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'hFFFF, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[22] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0,  16'hFFFE, 4'h0, 4'h0, 1'b0, 2'd0};

    bus.en = '0; bus.kick = '0; bus.clear = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_timeout = '0;

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; bus.en = tbl[i].en; bus.kick = tbl[i].kick; bus.clear = tbl[i].clear;
      bus.cfg_we = tbl[i].we; bus.cfg_ch = tbl[i].ch; bus.cfg_timeout = tbl[i].to;
      cycle();
      chk($sformatf("tbl%0d cnt0", i), bus.count_val[CNT_W-1:0], tbl[i].cnt0);
      chk($sformatf("tbl%0d warn", i), bus.warn, tbl[i].warn & {NUM_CH{WARN_ON}});
      chk($sformatf("tbl%0d expired", i), bus.expired, tbl[i].expd);
      chk($sformatf("tbl%0d any", i), bus.any_expired, tbl[i].any);
      chk($sformatf("tbl%0d first", i), bus.first_ch, tbl[i].first);
    end

    // ---- basic expiry: timeout 10, expired at edge 11 ----
    rst = 1'b1; bus.en = '0; bus.kick = '0; bus.clear = '0; bus.cfg_we = 1'b0;
    cycle();
    rst = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_timeout = 16'd10;
    cycle();
    bus.cfg_we = 1'b0; bus.en = 4'b0001;
    cycle();
    chk("basic load", bus.count_val[CNT_W-1:0], 16'd10);
    n = 0;
    while (!bus.expired[0] && n < 40) begin cycle(); n++; end
    chk("basic latency", n, 11);
    chk("basic first", bus.first_ch, 2'd0);
    chk("basic any", bus.any_expired, 1'b1);

    // ---- kick at edge 5 reloads, expiry moves to edge 16 ----
    bus.en = '0; bus.clear = 4'b0001;
    cycle();
    bus.clear = '0; bus.en = 4'b0001;
    cycle();
    for (int k = 1; k < 5; k++) cycle();
    bus.kick = 4'b0001;
    cycle();
    bus.kick = '0;
    chk("kick reload", bus.count_val[CNT_W-1:0], 16'd10);
    e = 5;
    while (!bus.expired[0] && e < 60) begin cycle(); e++; end
    chk("kick latency", e, 16);

    // ---- warn: timeout 20, warn rises with count reaching 8, kick clears it ----
    bus.en = '0; bus.clear = 4'b0001; bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_timeout = 16'd20;
    cycle();
    bus.clear = '0; bus.cfg_we = 1'b0; bus.en = 4'b0001;
    cycle();
    n = 0;
    while (bus.count_val[CNT_W-1:0] != 16'd9 && n < 30) begin cycle(); n++; end
    chk("warn reach 9", bus.count_val[CNT_W-1:0], 16'd9);
    chk("warn low at 9", bus.warn[0], 1'b0);
    cycle();
    chk("warn count 8", bus.count_val[CNT_W-1:0], 16'd8);
    chk("warn high at 8", bus.warn[0], WARN_ON);
    bus.kick = 4'b0001;
    cycle();
    bus.kick = '0;
    chk("warn kick cnt", bus.count_val[CNT_W-1:0], 16'd20);
    chk("warn kick clr", bus.warn[0], 1'b0);

    // ---- simultaneous expiry of ch1 and ch3 ----
    rst = 1'b1; bus.en = '0;
    cycle();
    rst = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_timeout = 16'd5;
    cycle();
    bus.cfg_ch = 2'd3;
    cycle();
    bus.cfg_we = 1'b0; bus.en = 4'b1010;
    cycle();
    n = 0;
    while (!bus.any_expired && n < 20) begin cycle(); n++; end
    chk("sim latency", n, 6);
    chk("sim expired", bus.expired, 4'b1010);
    chk("sim first", bus.first_ch, 2'd1);
    bus.en = '0; bus.clear = 4'b0010;
    cycle();
    chk("sim clr1 expired", bus.expired, 4'b1000);
    chk("sim clr1 first", bus.first_ch, 2'd1);
    chk("sim clr1 any", bus.any_expired, 1'b1);
    bus.clear = 4'b1000;
    cycle();
    bus.clear = '0;
    chk("sim clr3 any", bus.any_expired, 1'b0);
    chk("sim clr3 first", bus.first_ch, 2'd0);

    // ---- prescaler 4, timeout 3, mid-run write of 100 ----
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_timeout = 16'd3;
    cycle();
    bus.cfg_we = 1'b0; bus.en = 4'b0100;
    cycle();
    n = 0;
    while (!bus4.expired[2] && n < 40) begin
      bus.cfg_we = (n == 2); bus.cfg_ch = 2'd2; bus.cfg_timeout = 16'd100;
      cycle(); n++;
    end
    bus.cfg_we = 1'b0;
    chk("ps latency 13..16", (n >= 13 && n <= 16), 1'b1);
    bus.en = '0; bus.clear = 4'b0100;
    cycle();
    bus.clear = '0; bus.en = 4'b0100;
    cycle();
    chk("ps reload new to", bus4.count_val[2*CNT_W +: CNT_W], 16'd100);

    // ---- randomized against the reference model ----
    for (int r = 0; r < 1500; r++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        bus.en[c]    = ($urandom_range(0, 15) != 0);
        bus.kick[c]  = ($urandom_range(0, 15) == 0);
        bus.clear[c] = ($urandom_range(0, 5) == 0);
      end
      bus.cfg_we      = ($urandom_range(0, 3) == 0);
      bus.cfg_ch      = CH_W'($urandom);
      bus.cfg_timeout = CNT_W'($urandom_range(0, 24));
      cycle();
      compare_model(0);
      compare_model(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
